// File: rtl/dance_sequencer.sv
// Purpose : pattern/serial stimulus generator feeding the LightDance shift/load register.
// Latency : en seen at edge k -> load high in the cycle after edge k; frame = 1 + SHIFT_LEN cycles.
// Backpressure: none; en low stalls to IDLE (mid-SHIFT drop restarts the same pattern).
//
// Ports:
//   clk        system clock, rising edge
//   arst       asynchronous reset, active-low
//   en         run enable
//   mode       din source select, captured when leaving LOAD
//   load       parallel-load strobe (one cycle per frame)
//   pdata      ROM[pat_idx]
//   din        serial bit during SHIFT, 0 otherwise
//   pat_idx    current pattern index
//   busy       state != IDLE
//   frame_done high on the last SHIFT cycle of a frame
module dance_sequencer #(
    parameter int SHIFT_LEN = 8
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       load,
    output logic [7:0] pdata,
    output logic       din,
    output logic [1:0] pat_idx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT  = 8'(SHIFT_LEN - 1);
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    state_t     state_q, state_d;
    logic [1:0] pat_idx_q, pat_idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       alt_q, alt_d;
    logic [7:0] lfsr_q, lfsr_d;

    logic       load_q, load_d;
    logic       din_q, din_d;
    logic       busy_q, busy_d;
    logic       fdone_q, fdone_d;

    // Next-state logic for the sequencing registers.
    always_comb begin
        state_d   = state_q;
        pat_idx_d = pat_idx_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        alt_d     = alt_q;
        lfsr_d    = lfsr_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                mode_d  = mode;
                alt_d   = 1'b1;
                cnt_d   = 8'd0;
                state_d = en ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                cnt_d  = cnt_q + 8'd1;
                alt_d  = ~alt_q;
                // LFSR free-runs across frames; only reset reseeds it.
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                if (cnt_q == LAST_CNT) begin
                    // Completed frame advances the pattern even if en drops here.
                    pat_idx_d = pat_idx_q + 2'd1;
                    state_d   = en ? ST_LOAD : ST_IDLE;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered: decode them from the next-state values so they
    // line up with the state they describe.
    always_comb begin
        load_d  = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
        fdone_d = (state_d == ST_SHIFT) && (cnt_d == LAST_CNT);
        din_d   = 1'b0;
        if (state_d == ST_SHIFT) begin
            case (mode_d)
                2'd0:    din_d = 1'b0;
                2'd1:    din_d = 1'b1;
                2'd2:    din_d = alt_d;
                default: din_d = lfsr_d[7];
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= ST_IDLE;
            pat_idx_q <= 2'd0;
            cnt_q     <= 8'd0;
            mode_q    <= 2'd0;
            alt_q     <= 1'b1;
            lfsr_q    <= LFSR_SEED;
            load_q    <= 1'b0;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_idx_q <= pat_idx_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            alt_q     <= alt_d;
            lfsr_q    <= lfsr_d;
            load_q    <= load_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            fdone_q   <= fdone_d;
        end
    end

    always_comb begin
        case (pat_idx_q)
            2'd0:    pdata = 8'h55;
            2'd1:    pdata = 8'h0F;
            2'd2:    pdata = 8'h81;
            default: pdata = 8'h3C;
        endcase
    end

    assign load       = load_q;
    assign din        = din_q;
    assign busy       = busy_q;
    assign frame_done = fdone_q;
    assign pat_idx    = pat_idx_q;

endmodule

// File: doc/dance_sequencer.md
Name: dance_sequencer

Overview:
- Stimulus generator directly upstream of the LightDance shift/load register; drives its load, pdata and din inputs.
- Cycles through a fixed 4-entry pattern ROM. Each frame is one load cycle followed by SHIFT_LEN shift cycles.
- During the shift cycles, din comes from a selectable serial source.
- Provides busy/frame status for the top-level controller.

Parameters:
- SHIFT_LEN, 8, shift cycles per frame after the load cycle; legal range 1..255; counter width 8 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- arst  in  1  asynchronous reset, active-low; arst=0 forces reset state immediately.
- en  in  1  run enable; sampled every rising edge.
- mode  in  2  din source select; latched in the LOAD cycle.
- load  out  1  parallel-load strobe to the downstream register.
- pdata  out  8  pattern to the downstream register: ROM[pat_idx].
- din  out  1  serial bit to the downstream register.
- pat_idx  out  2  index of the current pattern.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  high for exactly the last SHIFT cycle of each frame.

Behaviour:
- Pattern ROM: idx0=8'h55, idx1=8'h0F, idx2=8'h81, idx3=8'h3C. pdata = ROM[pat_idx] at all times.
- States are IDLE, LOAD and SHIFT. Outputs are Moore, decoded from registered state and registers only.
- Reset (arst=0):
  - state=IDLE, pat_idx=0 (pdata=8'h55), load=0, din=0, busy=0, frame_done=0.
  - shift_cnt=0, mode_q=0, alt=1, lfsr=8'hA5.
- IDLE:
  - load=0, din=0.
  - en=1 at an edge -> LOAD.
- LOAD (exactly 1 cycle):
  - load=1, din=0.
  - At the edge leaving LOAD: mode_q<=mode, alt<=1, shift_cnt<=0.
  - Next state is SHIFT if en=1, otherwise IDLE.
- SHIFT:
  - load=0; din from mode_q:
    - 0: constant 0.
    - 1: constant 1.
    - 2: alt, starting 1 and toggling every SHIFT cycle, so the sequence is 1,0,1,0...
    - 3: lfsr[7].
  - Each SHIFT edge: shift_cnt+1; alt toggles; lfsr shifts left with feedback lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] into bit0.
  - lfsr advances only in SHIFT and is never reloaded except by reset.
  - frame_done=1 when shift_cnt==SHIFT_LEN-1.
  - At that edge: pat_idx<=pat_idx+1 (wraps 3->0), then next state is LOAD if en=1, otherwise IDLE.
- Frame length is 1+SHIFT_LEN cycles; the default is 9.
- Latency: en rising at edge k gives load=1 in the cycle after edge k.
- en deasserted mid-SHIFT:
  - Next edge -> IDLE; pat_idx is not incremented; frame_done is not asserted.
  - The next run restarts with LOAD of the same pat_idx.
- mode changes outside LOAD have no effect on the current frame.
- Async reset during LOAD or SHIFT: all outputs go to reset values immediately, with no wait for clk.
- Reset release: first active edge with en=1 enters LOAD.
- load and frame_done are never high in the same cycle. load is never high for 2 consecutive cycles.

Test Plan:
- Reset, then en=1, mode=1, SHIFT_LEN=8:
  - load=1 for 1 cycle with pdata=8'h55, then din=1 for 8 cycles.
  - frame_done is high in cycle 8 of SHIFT; the next load shows pdata=8'h0F.
- mode=2, run 4 full frames:
  - din per frame is 1,0,1,0,1,0,1,0.
  - pdata sequence is 55,0F,81,3C and then wraps to 55 with pat_idx=0.
- mode=3 from reset:
  - First SHIFT din bits are lfsr[7] starting from seed A5 (1,0,1,0,0,1,0,1...).
  - lfsr is not reloaded at the next LOAD.
- Change mode 1->0 mid-SHIFT: din stays 1 until the frame ends, and the next frame has din=0.
- Drop en at SHIFT cycle 3:
  - IDLE next cycle, busy=0, no frame_done, pat_idx unchanged.
  - Re-assert en: load repeats the same pdata.
- Pulse arst=0 for 3ns between clk edges during SHIFT:
  - load, din, busy and pat_idx drop to 0 immediately; pdata=8'h55.
  - Operation resumes at LOAD after release with en=1.
